game_tick_scheduler: RTL and testbench

Central timing controller for the Pong datapath. One shared prescaler generates a base tick, and the block schedules three enable pulses from it: ball motion, paddle motion and display refresh. It sequences game phases (idle, serve delay, play, pause) and raises ball speed as rallies lengthen. Downstream logic runs on clk and uses these one-cycle enables instead of derived clocks.

---
 rtl/pong_timing_pkg.sv | 28 ++
 rtl/tick_divider.sv | 31 +++
 rtl/game_tick_scheduler.sv | 199 +++++++++++++++++++
 tb/tb_game_tick_scheduler.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_timing_pkg.sv
// Shared timing definitions for the Pong tick scheduler: state encodings,
// prescaler and speed-level helpers.
package pong_timing_pkg;

    localparam int unsigned LEVEL_W   = 4;
    localparam int unsigned LEVEL_CAP = (1 << LEVEL_W) - 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SERVE  = 2'd1,
        ST_PLAY   = 2'd2,
        ST_PAUSED = 2'd3
    } state_t;

    function automatic int unsigned calc_presc(input int unsigned clk_hz,
                                               input int unsigned base_hz);
        return clk_hz / base_hz;
    endfunction

    // Highest useful level: one step per base tick of ball period, capped by the level field.
    function automatic int unsigned calc_level_max(input int unsigned div0,
                                                   input int unsigned div_min);
        int unsigned span;
        span = div0 - div_min;
        return (span > LEVEL_CAP) ? LEVEL_CAP : span;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Modulo counter with enable, sync clear and a runtime divisor; o_term_c marks
// the enabled cycle in which the count reaches (or passes) divisor-1.
module tick_divider #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_en,
    input  logic         i_clr,
    input  logic [W-1:0] i_div,
    output logic         o_term_c
);

    logic [W-1:0] r_cnt;
    logic         w_at_end;

    // >= so that a divisor shrinking below the current count wraps on the next step
    assign w_at_end = (r_cnt >= (i_div - W'(1)));
    assign o_term_c = i_en & w_at_end;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clr || o_term_c) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

endmodule

// File: rtl/game_tick_scheduler.sv
// Pong timing controller: shared prescaler, ball/paddle/refresh enables,
// game-phase FSM and rally-driven ball speed level.
module game_tick_scheduler
    import pong_timing_pkg::*;
#(
    parameter int unsigned CLK_HZ         = 100000000,
    parameter int unsigned BASE_HZ        = 1000,
    parameter int unsigned BALL_DIV0      = 10,
    parameter int unsigned BALL_DIV_MIN   = 3,
    parameter int unsigned HITS_PER_LEVEL = 4,
    parameter int unsigned PADDLE_DIV     = 5,
    parameter int unsigned SERVE_TICKS    = 1000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               pause_toggle,
    input  logic               hit,
    input  logic               point_scored,
    output logic               ball_tick,
    output logic               paddle_tick,
    output logic               mux_tick,
    output logic [1:0]         state,
    output logic [LEVEL_W-1:0] level
);

    localparam int unsigned PRESC     = calc_presc(CLK_HZ, BASE_HZ);
    localparam int unsigned PRESC_W   = $clog2(PRESC + 1);
    localparam int unsigned PADDLE_W  = $clog2(PADDLE_DIV + 1);
    localparam int unsigned BALL_W    = $clog2(BALL_DIV0 + 1);
    localparam int unsigned SERVE_W   = $clog2(SERVE_TICKS + 1);
    localparam int unsigned HIT_W     = $clog2(HITS_PER_LEVEL + 1);
    localparam int unsigned LEVEL_MAX = calc_level_max(BALL_DIV0, BALL_DIV_MIN);

    state_t               r_state;
    state_t               w_state_nxt;
    state_t               r_ret_state;
    state_t               w_ret_nxt;
    logic                 w_enter_serve;
    logic                 w_play_hit;
    logic                 w_level_clr;

    logic                 w_base_tick;
    logic                 w_paddle_term;
    logic                 w_ball_term;
    logic                 w_serve_term;
    logic                 w_run_paddle;
    logic                 w_run_ball;
    logic                 w_run_serve;
    logic [BALL_W-1:0]    w_ball_div;

    logic [LEVEL_W-1:0]   r_level;
    logic [HIT_W-1:0]     r_hit_cnt;
    logic                 r_ball_tick;
    logic                 r_paddle_tick;
    logic                 r_mux_tick;

    // Counter gating always uses the state before any same-cycle transition
    assign w_run_paddle = w_base_tick & ((r_state == ST_SERVE) || (r_state == ST_PLAY));
    assign w_run_ball   = w_base_tick & (r_state == ST_PLAY);
    assign w_run_serve  = w_base_tick & (r_state == ST_SERVE);

    always_comb begin
        w_ball_div = BALL_W'(BALL_DIV_MIN);
        if (32'(r_level) < (BALL_DIV0 - BALL_DIV_MIN)) begin
            w_ball_div = BALL_W'(BALL_DIV0 - 32'(r_level));
        end
    end

    tick_divider #(.W(PRESC_W)) u_presc (
        .clk      (clk),
        .reset    (reset),
        .i_en     (1'b1),
        .i_clr    (1'b0),
        .i_div    (PRESC_W'(PRESC)),
        .o_term_c (w_base_tick)
    );

    tick_divider #(.W(PADDLE_W)) u_paddle (
        .clk      (clk),
        .reset    (reset),
        .i_en     (w_run_paddle),
        .i_clr    (w_enter_serve),
        .i_div    (PADDLE_W'(PADDLE_DIV)),
        .o_term_c (w_paddle_term)
    );

    tick_divider #(.W(BALL_W)) u_ball (
        .clk      (clk),
        .reset    (reset),
        .i_en     (w_run_ball),
        .i_clr    (w_enter_serve),
        .i_div    (w_ball_div),
        .o_term_c (w_ball_term)
    );

    tick_divider #(.W(SERVE_W)) u_serve (
        .clk      (clk),
        .reset    (reset),
        .i_en     (w_run_serve),
        .i_clr    (w_enter_serve),
        .i_div    (SERVE_W'(SERVE_TICKS)),
        .o_term_c (w_serve_term)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_ret_state <= ST_SERVE;
        end else begin
            r_state     <= w_state_nxt;
            r_ret_state <= w_ret_nxt;
        end
    end

    // Priority inside a state: point_scored > pause_toggle > hit
    always_comb begin
        w_state_nxt   = r_state;
        w_ret_nxt     = r_ret_state;
        w_enter_serve = 1'b0;
        w_play_hit    = 1'b0;
        w_level_clr   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt   = ST_SERVE;
                    w_enter_serve = 1'b1;
                end
            end
            ST_SERVE: begin
                if (pause_toggle) begin
                    w_state_nxt = ST_PAUSED;
                    w_ret_nxt   = w_serve_term ? ST_PLAY : ST_SERVE;
                end else if (w_serve_term) begin
                    w_state_nxt = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (point_scored) begin
                    w_state_nxt   = ST_SERVE;
                    w_enter_serve = 1'b1;
                    w_level_clr   = 1'b1;
                end else if (pause_toggle) begin
                    w_state_nxt = ST_PAUSED;
                    w_ret_nxt   = ST_PLAY;
                end else if (hit) begin
                    w_play_hit = 1'b1;
                end
            end
            ST_PAUSED: begin
                if (pause_toggle) begin
                    w_state_nxt = r_ret_state;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Rally speed: hit_cnt keeps wrapping once the level saturates
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_level   <= '0;
            r_hit_cnt <= '0;
        end else if (w_level_clr) begin
            r_level   <= '0;
            r_hit_cnt <= '0;
        end else if (w_play_hit) begin
            if (r_hit_cnt == HIT_W'(HITS_PER_LEVEL - 1)) begin
                r_hit_cnt <= '0;
                if (r_level < LEVEL_W'(LEVEL_MAX)) begin
                    r_level <= r_level + LEVEL_W'(1);
                end
            end else begin
                r_hit_cnt <= r_hit_cnt + HIT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ball_tick   <= 1'b0;
            r_paddle_tick <= 1'b0;
            r_mux_tick    <= 1'b0;
        end else begin
            r_ball_tick   <= w_ball_term;
            r_paddle_tick <= w_paddle_term;
            r_mux_tick    <= w_base_tick;
        end
    end

    assign ball_tick   = r_ball_tick;
    assign paddle_tick = r_paddle_tick;
    assign mux_tick    = r_mux_tick;
    assign state       = r_state;
    assign level       = r_level;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Directed self-checking bench for game_tick_scheduler with PRESC=10,
// ball divisor 4 down to 2, two hits per level, paddle every 2, serve 3 ticks.
module tb_game_tick_scheduler;

    logic       clk;
    logic       reset;
    logic       start;
    logic       pause_toggle;
    logic       hit;
    logic       point_scored;
    logic       ball_tick;
    logic       paddle_tick;
    logic       mux_tick;
    logic [1:0] state;
    logic [3:0] level;

    int n_checks = 0;
    int n_errors = 0;

    game_tick_scheduler #(
        .CLK_HZ         (20),
        .BASE_HZ        (2),
        .BALL_DIV0      (4),
        .BALL_DIV_MIN   (2),
        .HITS_PER_LEVEL (2),
        .PADDLE_DIV     (2),
        .SERVE_TICKS    (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .pause_toggle (pause_toggle),
        .hit          (hit),
        .point_scored (point_scored),
        .ball_tick    (ball_tick),
        .paddle_tick  (paddle_tick),
        .mux_tick     (mux_tick),
        .state        (state),
        .level        (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor: index 0=ball, 1=paddle, 2=mux
    int         cyc = 0;
    int         pcnt[3]    = '{0, 0, 0};
    int         plast[3]   = '{0, 0, 0};
    int         pprev[3]   = '{0, 0, 0};
    int         t_enter[4] = '{0, 0, 0, 0};
    int         wide = 0;
    logic [2:0] tick_q = 3'b000;
    logic [1:0] st_q = 2'd0;
    logic [2:0] w_ticks;

    assign w_ticks = {mux_tick, paddle_tick, ball_tick};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (w_ticks[k]) begin
                pprev[k] = plast[k];
                plast[k] = cyc;
                pcnt[k]  = pcnt[k] + 1;
                if (tick_q[k]) wide = wide + 1;
            end
        end
        tick_q = w_ticks;
        if (state != st_q) t_enter[state] = cyc;
        st_q = state;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_next(input int sel, input int budget, input string tag);
        int c0;
        int n;
        c0 = pcnt[sel];
        n  = 0;
        while (pcnt[sel] == c0 && n < budget) begin
            tick_n(1);
            n++;
        end
        check_eq(tag, pcnt[sel], c0 + 1);
    endtask

    task automatic wait_state(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (int'(state) != target && n < budget) begin
            tick_n(1);
            n++;
        end
        check_eq(tag, int'(state), target);
    endtask

    int c_ball;
    int c_pad;
    int c_mux;

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        pause_toggle = 1'b0;
        hit          = 1'b0;
        point_scored = 1'b0;
        tick_n(3);
        check_eq("rst_state", int'(state), 0);
        check_eq("rst_level", int'(level), 0);
        check_eq("rst_ticks", int'(w_ticks), 0);

        // Idle 100 cycles; hit/pause in IDLE must be ignored
        reset = 1'b0;
        tick_n(50);
        hit = 1'b1; pause_toggle = 1'b1;
        tick_n(1);
        hit = 1'b0; pause_toggle = 1'b0;
        tick_n(49);
        check_eq("idle_state", int'(state), 0);
        check_eq("idle_level", int'(level), 0);
        check_eq("idle_mux_cnt", pcnt[2], 10);
        check_eq("idle_mux_period", plast[2] - pprev[2], 10);
        check_eq("idle_ball_cnt", pcnt[0], 0);
        check_eq("idle_paddle_cnt", pcnt[1], 0);

        // Serve then play at level 0
        start = 1'b1;
        tick_n(1);
        start = 1'b0;
        check_eq("serve_state", int'(state), 1);
        wait_next(0, 200, "ball_first_seen");
        check_eq("serve_len", t_enter[2] - t_enter[1], 29);
        check_eq("play_state", int'(state), 2);
        check_eq("ball_first_delay", plast[0] - t_enter[2], 40);
        check_eq("paddle_period", plast[1] - pprev[1], 20);
        wait_next(0, 100, "ball_second_seen");
        check_eq("ball_period_l0", plast[0] - pprev[0], 40);

        // Two hits -> level 1
        hit = 1'b1;
        tick_n(2);
        hit = 1'b0;
        check_eq("level_after_2hits", int'(level), 1);
        wait_next(0, 100, "ball_l1_seen");
        check_eq("ball_period_l1", plast[0] - pprev[0], 30);

        // Two more -> level 2
        hit = 1'b1;
        tick_n(2);
        hit = 1'b0;
        check_eq("level_after_4hits", int'(level), 2);
        wait_next(0, 100, "ball_l2_seen");
        check_eq("ball_period_l2", plast[0] - pprev[0], 20);

        // Four more -> saturated
        hit = 1'b1;
        tick_n(4);
        hit = 1'b0;
        check_eq("level_saturated", int'(level), 2);
        wait_next(0, 100, "ball_sat_seen");
        check_eq("ball_period_sat", plast[0] - pprev[0], 20);

        // Pause with ball counter at 1 of 2
        tick_n(11);
        pause_toggle = 1'b1;
        tick_n(1);
        pause_toggle = 1'b0;
        check_eq("paused_state", int'(state), 3);
        c_ball = pcnt[0];
        c_pad  = pcnt[1];
        c_mux  = pcnt[2];
        tick_n(20);
        start = 1'b1; hit = 1'b1; point_scored = 1'b1;
        tick_n(1);
        start = 1'b0; hit = 1'b0; point_scored = 1'b0;
        tick_n(29);
        check_eq("paused_hold_state", int'(state), 3);
        check_eq("paused_hold_level", int'(level), 2);
        check_eq("paused_ball_delta", pcnt[0] - c_ball, 0);
        check_eq("paused_paddle_delta", pcnt[1] - c_pad, 0);
        check_eq("paused_mux_delta", pcnt[2] - c_mux, 5);
        pause_toggle = 1'b1;
        tick_n(1);
        pause_toggle = 1'b0;
        check_eq("resume_state", int'(state), 2);
        wait_next(0, 50, "ball_resume_seen");
        check_eq("ball_resume_delay", plast[0] - t_enter[2], 7);
        check_eq("paddle_resume_delay", plast[1] - t_enter[2], 7);

        // Point scored -> serve, level cleared
        point_scored = 1'b1;
        tick_n(1);
        point_scored = 1'b0;
        check_eq("point_state", int'(state), 1);
        check_eq("point_level", int'(level), 0);
        wait_state(2, 100, "reserve_play");
        check_eq("reserve_len", t_enter[2] - t_enter[1], 29);

        // Three hits (level 1, hit_cnt 1), then hit+point+pause together
        hit = 1'b1;
        tick_n(3);
        check_eq("level_before_point", int'(level), 1);
        point_scored = 1'b1; pause_toggle = 1'b1;
        tick_n(1);
        hit = 1'b0; point_scored = 1'b0; pause_toggle = 1'b0;
        check_eq("combo_state", int'(state), 1);
        check_eq("combo_level", int'(level), 0);
        wait_state(2, 100, "combo_play");
        check_eq("combo_serve_len", t_enter[2] - t_enter[1], 26);
        hit = 1'b1;
        tick_n(1);
        hit = 1'b0;
        check_eq("hitcnt_cleared", int'(level), 0);
        wait_next(0, 100, "ball_after_combo_seen");
        check_eq("ball_after_combo", plast[0] - t_enter[2], 40);

        // Reach level 1, then reset one cycle before the next due ball tick
        hit = 1'b1;
        tick_n(1);
        hit = 1'b0;
        check_eq("level_pre_reset", int'(level), 1);
        tick_n(28);
        c_ball = pcnt[0];
        reset = 1'b1;
        #1;
        check_eq("midreset_state", int'(state), 0);
        check_eq("midreset_level", int'(level), 0);
        check_eq("midreset_ball", int'(ball_tick), 0);
        tick_n(3);
        reset = 1'b0;
        c_mux = pcnt[2];
        tick_n(30);
        check_eq("postreset_ball_delta", pcnt[0] - c_ball, 0);
        check_eq("postreset_state", int'(state), 0);
        check_eq("postreset_mux_delta", pcnt[2] - c_mux, 3);
        check_eq("pulse_width", wide, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
